// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmit and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StShift,
        StAck,
        StWaitIdle,
        StDone
    } ps2_tx_state_t;

    localparam int unsigned PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Request/status and open-collector line bundle of the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err;

    modport master (
        output tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_i, ps2_data_i,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a clock falling-edge strobe.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic clk_line,
    input  logic data_line,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);
    logic [1:0] clk_ff_q;
    logic [1:0] data_ff_q;
    logic       clk_prev_q;

    // Idle bus level is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_ff_q   <= 2'b11;
            data_ff_q  <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_ff_q   <= {clk_ff_q[0], clk_line};
            data_ff_q  <= {data_ff_q[0], data_line};
            clk_prev_q <= clk_ff_q[1];
        end
    end

    assign clk_sync  = clk_ff_q[1];
    assign data_sync = data_ff_q[1];
    assign clk_fall  = clk_prev_q & ~clk_ff_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, 11-bit frame, device ACK.
// Defining PS2_TX_TIMEOUT_EN adds a watchdog from clock release to end of frame.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input logic          clk,
    input logic          reset,
    ps2_host_tx_if.slave bus
);
    localparam int unsigned CntMax =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);

    ps2_tx_state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [8:0]      shift_q, shift_d;
    logic            data_oe_q, data_oe_d;
    logic            ack_q, ack_d;

    logic clk_s, data_s, clk_fall;
    logic tx_ready, busy, clk_oe, data_oe, done, ack_ok, err;

    ps2_line_sync u_line_sync (
        .clk       (clk),
        .reset     (reset),
        .clk_line  (bus.ps2_clk_i),
        .data_line (bus.ps2_data_i),
        .clk_sync  (clk_s),
        .data_sync (data_s),
        .clk_fall  (clk_fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_oe_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_oe_q <= data_oe_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_oe_d = data_oe_q;
        ack_d     = ack_q;
        tx_ready  = 1'b0;
        busy      = 1'b1;
        clk_oe    = 1'b0;
        data_oe   = 1'b0;
        done      = 1'b0;
        ack_ok    = 1'b0;
        err       = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (bus.tx_valid) begin
                    shift_d   = {odd_parity(bus.tx_data), bus.tx_data};
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    ack_d     = 1'b0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                clk_oe = 1'b1;
                cnt_d  = cnt_q + CntW'(1);
                // Start bit goes out in the last inhibit cycle and is held into SHIFT.
                if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                    data_oe   = 1'b1;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                data_oe = data_oe_q;
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(PS2_FRAME_BITS - 2)) begin
                        data_oe_d = 1'b0;
                        state_d   = StAck;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            StAck: begin
                if (clk_fall) begin
                    ack_d   = ~data_s;
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_s && data_s) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                ack_ok  = ack_q;
                err     = ~ack_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Placed last so an expiring watchdog overrides any edge in the same cycle.
        if (state_q inside {StShift, StAck, StWaitIdle}) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                ack_d     = 1'b0;
                data_oe_d = 1'b0;
                state_d   = StDone;
            end
        end
`endif
    end

    assign bus.tx_ready    = tx_ready;
    assign bus.busy        = busy;
    assign bus.ps2_clk_oe  = clk_oe;
    assign bus.ps2_data_oe = data_oe;
    assign bus.done        = done;
    assign bus.ack_ok      = ack_ok;
    assign bus.err         = err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model, randomized bytes and ACK/NACK.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned Inh  = 40;
    localparam int unsigned Tmo  = 1000;
    localparam int          Half = 20;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    assign bus.ps2_clk_i  = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_data_i = ~(bus.ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (Inh),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic line_q[$];

    always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected line levels: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d, output logic ready, output logic oe_next,
                            output int inh_len);
        line_q.delete();
        ready        = bus.tx_ready;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        cyc(1);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        oe_next      = bus.ps2_clk_oe;
        inh_len      = 0;
        while (bus.ps2_clk_oe === 1'b1 && inh_len < int'(Inh) + 50) begin
            inh_len++;
            cyc(1);
        end
        line_q.push_back(bus.ps2_data_i);
    endtask

    task automatic dev_edges(input int n);
        repeat (n) begin
            cyc(Half);
            dev_clk_low = 1'b1;
            cyc(Half);
            line_q.push_back(bus.ps2_data_i);
            dev_clk_low = 1'b0;
        end
    endtask

    task automatic dev_ack(input logic ack);
        cyc(Half / 2);
        dev_data_low = ack;
        cyc(Half / 2);
        dev_clk_low = 1'b1;
        cyc(Half);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int waited, output logic a, output logic e);
        waited = 0;
        while (bus.done !== 1'b1 && waited < bound) begin
            cyc(1);
            waited++;
        end
        a = bus.ack_ok;
        e = bus.err;
    endtask

    function automatic logic [10:0] line_bits();
        logic [10:0] got = '0;
        for (int i = 0; i < line_q.size() && i < 11; i++) got[i] = line_q[i];
        return got;
    endfunction

    task automatic test_reset();
        reset        = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = PS2_CMD_RESET;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            checks++;
            if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy, bus.tx_ready, bus.done,
                 bus.ack_ok, bus.err} !== 7'b0001000) begin
                failures++;
                $display("FAIL reset_state got=%b exp=0001000", {bus.ps2_clk_oe,
                         bus.ps2_data_oe, bus.busy, bus.tx_ready, bus.done, bus.ack_ok, bus.err});
            end
        end
        bus.tx_valid = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(2);
    endtask

    task automatic test_frame(input logic [7:0] d, input logic ack);
        logic ready, oe_next, a, e;
        int inh, w, base;
        base = done_cnt;
        start_tx(d, ready, oe_next, inh);
        checks++;
        if (ready !== 1'b1 || oe_next !== 1'b1) begin
            failures++;
            $display("FAIL accept d=%h ready=%b clk_oe_next=%b exp=1/1", d, ready, oe_next);
        end
        checks++;
        if (inh != int'(Inh)) begin
            failures++;
            $display("FAIL inhibit_len d=%h got=%0d exp=%0d", d, inh, Inh);
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_in_frame busy=%b ready=%b exp=1/0", bus.busy, bus.tx_ready);
        end
        dev_edges(10);
        dev_ack(ack);
        checks++;
        if (line_q.size() != 11 || line_bits() !== frame_of(d)) begin
            failures++;
            $display("FAIL frame_bits d=%h got=%b n=%0d exp=%b", d, line_bits(),
                     line_q.size(), frame_of(d));
        end
        wait_done(100, w, a, e);
        checks++;
        if (bus.done !== 1'b1 || a !== ack || e !== ~ack) begin
            failures++;
            $display("FAIL result d=%h done=%b ack_ok=%b err=%b exp=1/%b/%b", d, bus.done,
                     a, e, ack, ~ack);
        end
        cyc(1);
        checks++;
        if (bus.done !== 1'b0 || bus.tx_ready !== 1'b1 || done_cnt != base + 1) begin
            failures++;
            $display("FAIL done_pulse done=%b ready=%b pulses=%0d exp=0/1/1", bus.done,
                     bus.tx_ready, done_cnt - base);
        end
    endtask

    task automatic test_ack_frames();
        test_frame(PS2_CMD_SET_LEDS, 1'b1);
        test_frame(8'h07, 1'b0);
        for (int i = 0; i < 3; i++) test_frame(8'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_mid_reset();
        logic ready, oe_next;
        logic [7:0] d;
        int inh, base;
        d = 8'($urandom) & 8'hF7;  // d3 = 0 so data_oe is asserted after edge 4
        base = done_cnt;
        start_tx(d, ready, oe_next, inh);
        dev_edges(4);
        checks++;
        if (bus.ps2_data_oe !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_data_oe got=%b exp=1", bus.ps2_data_oe);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.ps2_clk_oe !== 1'b0 || bus.ps2_data_oe !== 1'b0 || bus.tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset clk_oe=%b data_oe=%b ready=%b exp=0/0/1",
                     bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc(2);
        checks++;
        if (done_cnt != base) begin
            failures++;
            $display("FAIL reset_no_done pulses=%0d exp=0", done_cnt - base);
        end
        test_frame(PS2_CMD_RESET, 1'b1);
    endtask

    task automatic test_ignore_busy();
        logic ready, oe_next, a, e;
        logic [7:0] d;
        int inh, w, base, oe_seen;
        d = 8'($urandom);
        if (d == 8'h55) d = 8'hAA;
        base = done_cnt;
        start_tx(d, ready, oe_next, inh);
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        cyc(3);
        bus.tx_valid = 1'b0;
        dev_edges(10);
        dev_ack(1'b1);
        checks++;
        if (line_bits() !== frame_of(d)) begin
            failures++;
            $display("FAIL ignore_bits got=%b exp=%b", line_bits(), frame_of(d));
        end
        wait_done(100, w, a, e);
        oe_seen = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (bus.ps2_clk_oe === 1'b1) oe_seen++;
        end
        checks++;
        if (oe_seen != 0 || done_cnt != base + 1) begin
            failures++;
            $display("FAIL ignore_queue clk_oe_cycles=%0d pulses=%0d exp=0/1", oe_seen,
                     done_cnt - base);
        end
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout();
        logic ready, oe_next, a, e;
        int inh, w;
        start_tx(8'($urandom), ready, oe_next, inh);
        wait_done(int'(Tmo) + 50, w, a, e);
        checks++;
        if (w != int'(Tmo)) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=%0d", w, Tmo);
        end
        checks++;
        if (bus.done !== 1'b1 || a !== 1'b0 || e !== 1'b1 ||
            bus.ps2_clk_oe !== 1'b0 || bus.ps2_data_oe !== 1'b0) begin
            failures++;
            $display("FAIL timeout_result done=%b ack_ok=%b err=%b oe=%b%b exp=1/0/1/00",
                     bus.done, a, e, bus.ps2_clk_oe, bus.ps2_data_oe);
        end
        cyc(1);
        checks++;
        if (bus.tx_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle ready=%b busy=%b exp=1/0", bus.tx_ready, bus.busy);
        end
    endtask
`else
    task automatic test_timeout();
        logic ready, oe_next;
        int inh, base;
        base = done_cnt;
        start_tx(8'($urandom), ready, oe_next, inh);
        cyc(int'(Tmo) + 50);
        checks++;
        if (bus.busy !== 1'b1 || done_cnt != base) begin
            failures++;
            $display("FAIL no_watchdog busy=%b pulses=%0d exp=1/0", bus.busy, done_cnt - base);
        end
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(2);
        checks++;
        if (bus.tx_ready !== 1'b1 || bus.ps2_data_oe !== 1'b0) begin
            failures++;
            $display("FAIL no_watchdog_recover ready=%b data_oe=%b exp=1/0", bus.tx_ready,
                     bus.ps2_data_oe);
        end
    endtask
`endif

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_ack_frames();
        test_mid_reset();
        test_ignore_busy();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
